line_memory: RTL and testbench

Backing-store responder for the direct-mapped cache's miss/write-back port. Holds MEM_LINES cache lines and services one whole-line read or write per request after a fixed, parameterised latency. Answers with a one-cycle `satisfied` pulse, so a requester that holds `req` high across a write-back followed by a refill gets two distinct, sequential transactions.

---
 rtl/line_memory.sv | 121 ++++++++++++
 tb/tb_line_memory.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/line_memory.sv
// line_memory: fixed-latency whole-line backing store behind the cache miss port.
// Each request is serviced after LATENCY busy cycles and acknowledged by a one-cycle pulse.
module line_memory #(
  parameter int REGISTER_SIZE = 32,
  parameter int REGS_PER_LINE = 4,
  parameter int LINE_LENGTH   = REGISTER_SIZE * REGS_PER_LINE,
  parameter int ADDRESS_SIZE  = 32,
  parameter int MEM_LINES     = 64,
  parameter int LATENCY       = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req,
  input  logic [ADDRESS_SIZE-1:0] address,
  input  logic                    write,
  input  logic [LINE_LENGTH-1:0]  data_in,
  output logic [LINE_LENGTH-1:0]  result,
  output logic                    satisfied,
  output logic                    busy
);

  localparam int OW = $clog2(REGS_PER_LINE);
  localparam int IW = $clog2(MEM_LINES);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]          r_cnt;
  logic [IW-1:0]          r_idx;
  logic                   r_wr;
  logic [LINE_LENGTH-1:0] r_data;
  logic [LINE_LENGTH-1:0] r_result;
  logic [LINE_LENGTH-1:0] r_mem [MEM_LINES];

  logic          w_sample;
  logic          w_last;
  logic          w_busy;
  logic          w_sat;
  logic [IW-1:0] w_line_idx;
  logic          w_addr_unused;

  // Offset bits and high bits alias onto the same line by design.
  assign w_line_idx    = address[OW +: IW];
  assign w_addr_unused = ^address;

  assign w_sample = (r_state == S_IDLE) && req;
  assign w_last   = (r_state == S_BUSY) && (r_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (req) w_next = S_BUSY;
      S_BUSY: if (r_cnt == '0) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_sat  = 1'b0;
    unique case (r_state)
      S_BUSY: w_busy = 1'b1;
      S_DONE: begin
        w_busy = 1'b1;
        w_sat  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_idx    <= '0;
      r_wr     <= 1'b0;
      r_data   <= '0;
      r_result <= '0;
    end else begin
      if (w_sample) begin
        r_cnt  <= CW'(LATENCY - 1);
        r_idx  <= w_line_idx;
        r_wr   <= write;
        r_data <= data_in;
      end else if ((r_state == S_BUSY) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_last && !r_wr) begin
        r_result <= r_mem[r_idx];
      end
    end
  end

  // Storage is deliberately outside the reset domain; an aborted write never
  // reaches w_last because reset forces the state back to idle.
  always_ff @(posedge clk) begin
    if (w_last && r_wr) begin
      r_mem[r_idx] <= r_data;
    end
  end

  assign result    = r_result;
  assign satisfied = w_sat;
  assign busy      = w_busy;

endmodule

// File: tb/tb_line_memory.sv
// tb_line_memory: randomized transactions against an array model of the line store.
// Checks pulse timing, busy window, read data, aliasing and reset abort.
module tb_line_memory;

  localparam int RS  = 32;
  localparam int RPL = 4;
  localparam int LL  = RS * RPL;
  localparam int AS  = 32;
  localparam int ML  = 64;
  localparam int LAT = 5;

  logic          clk;
  logic          reset;
  logic          req;
  logic [AS-1:0] address;
  logic          write;
  logic [LL-1:0] data_in;
  logic [LL-1:0] result;
  logic          satisfied;
  logic          busy;

  int n_chk;
  int n_fail;

  logic [LL-1:0] m_mem [ML];
  logic [LL-1:0] m_res;

  line_memory #(
    .REGISTER_SIZE(RS),
    .REGS_PER_LINE(RPL),
    .ADDRESS_SIZE (AS),
    .MEM_LINES    (ML),
    .LATENCY      (LAT)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .address  (address),
    .write    (write),
    .data_in  (data_in),
    .result   (result),
    .satisfied(satisfied),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LL-1:0] got,
                     input logic [LL-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int line_of(input logic [AS-1:0] a);
    return int'((a / RPL) % ML);
  endfunction

  function automatic logic [LL-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a negedge with the DUT idle (or in DONE when chained).
  task automatic txn(input logic w, input logic [AS-1:0] a,
                     input logic [LL-1:0] d, input bit chained,
                     input bit keep, input bit scramble);
    int idx;
    idx     = line_of(a);
    req     = 1'b1;
    write   = w;
    address = a;
    data_in = d;
    if (chained) begin
      @(posedge clk);
      @(negedge clk);
      chk("done_no_resample_busy", busy, 0);
      chk("done_no_resample_sat", satisfied, 0);
    end
    @(posedge clk);
    for (int c = 1; c <= LAT + 1; c++) begin
      @(negedge clk);
      chk("busy_window", busy, 1);
      chk("sat_timing", satisfied, (c == LAT + 1) ? 1 : 0);
      if (c == LAT + 1) begin
        if (w) m_mem[idx] = d;
        else   m_res = m_mem[idx];
        chk(w ? "result_after_write" : "read_data", result, m_res);
      end else if (scramble) begin
        req     = 1'($urandom);
        write   = 1'($urandom);
        address = $urandom;
        data_in = rnd_line();
      end
    end
    if (!keep) begin
      req = 1'b0;
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_sat", satisfied, 0);
    end
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("no_stray_pulse", satisfied, 0);
    end
  endtask

  initial begin
    logic [LL-1:0] a_line;
    logic [LL-1:0] b_line;
    logic [LL-1:0] c_line;
    n_chk   = 0;
    n_fail  = 0;
    reset   = 1'b0;
    req     = 1'b0;
    write   = 1'b0;
    address = '0;
    data_in = '0;
    m_res   = '0;
    for (int i = 0; i < ML; i++) m_mem[i] = '0;

    #2 reset = 1'b1;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_sat", satisfied, 0);
    chk("reset_result", result, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Give every line a known value so the model needs no power-up assumption.
    for (int i = 0; i < ML; i++) txn(1'b1, AS'(i * RPL), '0, 0, 0, 0);

    txn(1'b1, 32'h10,
        128'h44444444_33333333_22222222_11111111, 0, 0, 0);
    txn(1'b0, 32'h13, '0, 0, 0, 0);
    chk("same_line_read", result,
        128'h44444444_33333333_22222222_11111111);
    quiet(4);

    a_line = rnd_line();
    txn(1'b1, 32'h20, a_line, 0, 1, 0);
    txn(1'b0, 32'h40, '0, 1, 0, 0);
    quiet(3);
    txn(1'b0, 32'h20, '0, 0, 0, 0);
    chk("held_req_write", result, a_line);

    b_line = rnd_line();
    txn(1'b1, 32'h04, b_line, 0, 0, 0);
    txn(1'b0, 32'h104, '0, 0, 0, 0);
    chk("alias_read", result, b_line);

    // Abort a write to line 3 two cycles after it was sampled.
    c_line  = rnd_line();
    req     = 1'b1;
    write   = 1'b1;
    address = 32'h0C;
    data_in = c_line;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    req   = 1'b0;
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_sat", satisfied, 0);
    chk("abort_result", result, 0);
    m_res = '0;
    @(negedge clk);
    reset = 1'b0;
    quiet(LAT + 3);
    txn(1'b0, 32'h0C, '0, 0, 0, 0);
    chk("aborted_write_lost", result, 0);

    txn(1'b1, 32'h30, c_line, 0, 0, 1);
    txn(1'b0, 32'h33, '0, 0, 0, 1);
    chk("scrambled_inputs", result, c_line);

    for (int i = 0; i < 60; i++) begin
      logic [AS-1:0] a;
      a = (i % 3 == 0) ? AS'($urandom) : AS'($urandom_range(0, 8 * RPL - 1));
      txn(1'($urandom), a, rnd_line(), 0, 0, 1'($urandom));
    end
    quiet(3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
